// File: rtl/fp16_mant_div.sv
// Radix-2 restoring divider for fp16 significands (hidden bit included).
// Resolves one quotient bit per cycle and reports a sticky bit and divide-by-zero.
module fp16_mant_div #(
    parameter int MANT_W = 11,
    parameter int QUOT_W = MANT_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [QUOT_W-1:0] q,
    output logic              sticky,
    output logic              dz
);

    localparam int CNT_W = $clog2(QUOT_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [MANT_W:0]   r_rem;
    logic [MANT_W-1:0] r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic [QUOT_W-1:0] r_q;
    logic              r_sticky;
    logic              r_dz;

    logic              w_accept;
    logic              w_ge;
    logic [MANT_W:0]   w_diff;
    logic              w_ops_ok;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid = (r_state == S_DONE);
    assign q         = r_q;
    assign sticky    = r_sticky;
    assign dz        = r_dz;

    assign w_accept = in_valid & in_ready;
    assign w_ge     = (r_rem >= {1'b0, r_b});
    assign w_diff   = w_ge ? (r_rem - {1'b0, r_b}) : r_rem;

    // w_diff < b always, so its top bit is zero and the left shift loses nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_q      <= '0;
            r_sticky <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_q   <= {r_q[QUOT_W-2:0], w_ge};
                    r_rem <= {w_diff[MANT_W-1:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_sticky <= (w_diff != '0);
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_b      <= b;
                        r_rem    <= {1'b0, a};
                        r_cnt    <= CNT_W'(QUOT_W - 1);
                        r_sticky <= 1'b0;
                        r_dz     <= (b == '0);
                        r_q      <= (b == '0) ? '1 : '0;
                        r_state  <= (b == '0) ? S_DONE : S_BUSY;
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Operands must be normalised (hidden bit set) or exactly zero.
    assign w_ops_ok = ((a == '0) | a[MANT_W-1]) & ((b == '0) | b[MANT_W-1]);

    a_ops_normalised: assert property (@(posedge clk) disable iff (rst) w_accept |-> w_ops_ok);

endmodule
